// File: rtl/adc_bcd_readout.sv
// SPI ADC readout: captures one or more frames, averages them and converts the
// result to ASCII decimal digits with an iterative shift-add-3 converter.
`timescale 1ns/1ps
module adc_bcd_readout #(
   parameter int FRAME_BITS = 16,
   parameter int RES_BITS   = 12,
   parameter int DIGITS     = 4,
   parameter int AVG_LOG2   = 2,
   parameter int CLK_DIV    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  cont,
   input  logic                  miso,
   output logic                  ss,
   output logic                  sclk,
   output logic                  busy,
   output logic                  done,
   output logic                  ovf,
   output logic [RES_BITS-1:0]   raw_avg,
   output logic [DIGITS*8-1:0]   ascii
);

   localparam int ACC_W  = RES_BITS + AVG_LOG2;
   localparam int DIV_W  = $clog2(CLK_DIV) + 1;
   localparam int EDGE_W = $clog2(2 * FRAME_BITS) + 1;
   localparam int GAP_W  = $clog2(2 * CLK_DIV) + 1;
   localparam int BIT_W  = $clog2(RES_BITS) + 1;
   localparam int FC_W   = AVG_LOG2 + 1;
   localparam int BCD_W  = 4 * DIGITS;
   localparam logic [63:0] MAX_VAL = 64'(10 ** DIGITS - 1);

   typedef enum logic [2:0] {IDLE, FRAME, GAP, AVG, BCD, DONE} state_t;

   state_t              state;
   state_t              state_next;
   logic [DIV_W-1:0]    div_cnt;
   logic [EDGE_W-1:0]   edge_cnt;
   logic [GAP_W-1:0]    gap_cnt;
   logic [FC_W-1:0]     frame_cnt;
   logic [BIT_W-1:0]    bit_cnt;
   logic [RES_BITS-1:0] shift_reg;
   logic [ACC_W-1:0]    acc;
   logic [RES_BITS-1:0] avg_val;
   logic [RES_BITS-1:0] bin_shift;
   logic [BCD_W-1:0]    bcd;
   logic [BCD_W-1:0]    bcd_adj;
   logic [BCD_W-1:0]    bcd_next;
   logic [DIGITS*8-1:0] ascii_next;
   logic                ovf_next;
   logic                div_tick;
   logic                last_edge;
   logic                capture;
   logic                gap_end;
   logic                all_frames;
   logic                bcd_end;
   logic                acc_clear;

   assign div_tick   = (div_cnt == DIV_W'(CLK_DIV - 1));
   assign last_edge  = (state == FRAME) && div_tick && (edge_cnt == EDGE_W'(2 * FRAME_BITS - 1));
   // Rising sclk edges sit on even edge counts; only the top RES_BITS bits are kept.
   assign capture    = (state == FRAME) && div_tick && !sclk && (edge_cnt < EDGE_W'(2 * RES_BITS));
   assign gap_end    = (gap_cnt == GAP_W'(2 * CLK_DIV - 1));
   assign all_frames = (frame_cnt == FC_W'(1 << AVG_LOG2));
   assign bcd_end    = (bit_cnt == BIT_W'(RES_BITS - 1));
   assign acc_clear  = ((state == IDLE) && start) || (state == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      busy       = (state != IDLE);
      done       = (state == DONE);
      case (state)
         IDLE:    if (start) state_next = FRAME;
         FRAME:   if (last_edge) state_next = GAP;
         GAP:     if (gap_end) state_next = all_frames ? AVG : FRAME;
         AVG:     state_next = BCD;
         BCD:     if (bcd_end) state_next = DONE;
         DONE:    state_next = cont ? FRAME : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // One shift-add-3 step per cycle; the final step feeds the output registers directly.
   always_comb begin
      bcd_adj = bcd;
      for (int d = 0; d < DIGITS; d++) begin
         if (bcd[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
      end
      bcd_next   = BCD_W'({bcd_adj, bin_shift[RES_BITS-1]});
      ovf_next   = (64'(avg_val) > MAX_VAL);
      ascii_next = '0;
      for (int d = 0; d < DIGITS; d++) begin
         ascii_next[8*d +: 8] = ovf_next ? 8'h39 : {4'h3, bcd_next[4*d +: 4]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ss        <= 1'b1;
         sclk      <= 1'b0;
         div_cnt   <= '0;
         edge_cnt  <= '0;
         gap_cnt   <= '0;
         frame_cnt <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
         acc       <= '0;
         avg_val   <= '0;
         bin_shift <= '0;
         bcd       <= '0;
         ovf       <= 1'b0;
         raw_avg   <= '0;
         ascii     <= {DIGITS{8'h30}};
      end else begin
         ss <= (state_next != FRAME);
         if (state == FRAME) begin
            if (div_tick) begin
               div_cnt  <= '0;
               sclk     <= ~sclk;
               edge_cnt <= last_edge ? '0 : edge_cnt + 1'b1;
            end else begin
               div_cnt <= div_cnt + 1'b1;
            end
         end else begin
            div_cnt  <= '0;
            sclk     <= 1'b0;
            edge_cnt <= '0;
         end
         if (capture) shift_reg <= RES_BITS'({shift_reg, miso});
         gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
         if (acc_clear) begin
            acc       <= '0;
            frame_cnt <= '0;
         end else if (last_edge) begin
            acc       <= acc + ACC_W'(shift_reg);
            frame_cnt <= frame_cnt + 1'b1;
         end
         if (state == AVG) begin
            avg_val   <= acc[ACC_W-1 -: RES_BITS];
            bin_shift <= acc[ACC_W-1 -: RES_BITS];
            bcd       <= '0;
            bit_cnt   <= '0;
         end else if (state == BCD) begin
            bcd       <= bcd_next;
            bin_shift <= bin_shift << 1;
            bit_cnt   <= bit_cnt + 1'b1;
         end
         if ((state == BCD) && bcd_end) begin
            raw_avg <= avg_val;
            ovf     <= ovf_next;
            ascii   <= ascii_next;
         end
      end
   end

endmodule

// File: tb/tb_adc_bcd_readout.sv
// Bench for adc_bcd_readout: three instances (no averaging, 4-frame averaging,
// 3-digit overflow) each driven by a serial ADC model and checked by a scoreboard.
`timescale 1ns/1ps
module tb_adc_bcd_readout;

   localparam int CLK_PERIOD = 10;

   typedef struct packed {
      logic [11:0] raw;
      logic [31:0] asc;
      logic        ov;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [2:0]  start_v = '0;
   logic [2:0]  cont_v  = '0;
   logic [2:0]  miso_v;
   logic [2:0]  ss_v;
   logic [2:0]  sclk_v;
   logic [2:0]  busy_v;
   logic [2:0]  done_v;
   logic [2:0]  ovf_v;
   logic [11:0] raw_v   [3];
   wire  [31:0] ascii_v [3];
   wire  [31:0] frame_cnt [3];
   wire  [31:0] rise_cnt  [3];
   wire  [31:0] done_cnt  [3];
   wire  [31:0] min_gap   [3];
   wire  [31:0] sclk_viol [3];
   wire  [31:0] done_viol [3];
   wire  [31:0] extra_done[3];
   logic [15:0] frame_q [3][$];
   exp_t        exp_q   [3][$];
   int          pass_count  = 0;
   int          check_count = 0;

   always #(CLK_PERIOD / 2) clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      check_count++;
      if (act === exp) pass_count++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   for (genvar k = 0; k < 3; k++) begin : inst
      localparam int DG = (k == 2) ? 3 : 4;
      localparam int AL = (k == 1) ? 2 : 0;
      logic [DG*8-1:0] asc;
      logic [15:0]     cur = '0;
      logic [3:0]      bit_idx = 4'd15;
      int              frames = 0, rises = 0, dones = 0, gap = 1000000;
      int              sv = 0, dv = 0, extra = 0, gap_now;
      time             t_rise = 0;
      bit              has_rise = 1'b0;
      logic            prev_sclk = 1'b0, prev_ss = 1'b1, prev_busy = 1'b0;
      exp_t            e;

      adc_bcd_readout #(.DIGITS(DG), .AVG_LOG2(AL)) dut (
         .clk(clk), .rst(rst), .start(start_v[k]), .cont(cont_v[k]), .miso(miso_v[k]),
         .ss(ss_v[k]), .sclk(sclk_v[k]), .busy(busy_v[k]), .done(done_v[k]),
         .ovf(ovf_v[k]), .raw_avg(raw_v[k]), .ascii(asc)
      );

      assign ascii_v[k]    = 32'(asc);
      assign miso_v[k]     = cur[bit_idx];
      assign frame_cnt[k]  = frames;
      assign rise_cnt[k]   = rises;
      assign done_cnt[k]   = dones;
      assign min_gap[k]    = gap;
      assign sclk_viol[k]  = sv;
      assign done_viol[k]  = dv;
      assign extra_done[k] = extra;

      // ADC model: MSB presented when ss falls, next bit after each sclk fall.
      always @(negedge ss_v[k]) begin
         if (frame_q[k].size() > 0) cur = frame_q[k].pop_front();
         else cur = 16'h0000;
         bit_idx = 4'd15;
         frames++;
         if (has_rise) begin
            gap_now = int'(($time - t_rise) / CLK_PERIOD);
            if (gap_now < gap) gap = gap_now;
         end
      end
      always @(posedge ss_v[k]) if (!rst) begin t_rise = $time; has_rise = 1'b1; end
      always @(negedge sclk_v[k]) if (bit_idx != 4'd0) bit_idx--;
      always @(posedge sclk_v[k]) rises++;

      always @(negedge clk) begin
         if (!rst) begin
            if ((sclk_v[k] != prev_sclk) && prev_ss) sv++;
            if (done_v[k] && !prev_busy) dv++;
            if (done_v[k]) begin
               dones++;
               if (exp_q[k].size() == 0) extra++;
               else begin
                  e = exp_q[k].pop_front();
                  check_output($sformatf("inst%0d_raw_avg", k), 32'(raw_v[k]), 32'(e.raw));
                  check_output($sformatf("inst%0d_ascii", k), ascii_v[k], e.asc);
                  check_output($sformatf("inst%0d_ovf", k), 32'(ovf_v[k]), 32'(e.ov));
               end
            end
         end
         prev_sclk = sclk_v[k];
         prev_ss   = ss_v[k];
         prev_busy = busy_v[k];
      end
   end

   task automatic push_expect(input int k, input logic [11:0] raw, input logic [31:0] asc, input logic ov);
      exp_t e;
      e = {raw, asc, ov};
      exp_q[k].push_back(e);
   endtask

   task automatic pulse_start(input int k);
      @(negedge clk);
      start_v[k] = 1'b1;
      @(negedge clk);
      start_v[k] = 1'b0;
   endtask

   task automatic apply_stimulus(input int k, input logic [15:0] frame, input logic [11:0] raw,
                                 input logic [31:0] asc, input logic ov);
      frame_q[k].push_back(frame);
      push_expect(k, raw, asc, ov);
      pulse_start(k);
   endtask

   task automatic wait_done(input int k, input int target, input int budget, input string name);
      int n = 0;
      while ((int'(done_cnt[k]) < target) && (n < budget)) begin
         @(negedge clk);
         n++;
      end
      check_output({name, "_done_count"}, done_cnt[k], 32'(target));
   endtask

   initial begin
      int fb, rb, n;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check_output($sformatf("inst%0d_reset_ss", k), 32'(ss_v[k]), 32'd1);
         check_output($sformatf("inst%0d_reset_sclk", k), 32'(sclk_v[k]), 32'd0);
         check_output($sformatf("inst%0d_reset_busy", k), 32'(busy_v[k]), 32'd0);
         check_output($sformatf("inst%0d_reset_done", k), 32'(done_v[k]), 32'd0);
         check_output($sformatf("inst%0d_reset_ovf", k), 32'(ovf_v[k]), 32'd0);
         check_output($sformatf("inst%0d_reset_raw", k), 32'(raw_v[k]), 32'd0);
         check_output($sformatf("inst%0d_reset_ascii", k), ascii_v[k],
                      (k == 2) ? 32'h00303030 : 32'h30303030);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Single frame, no averaging: 0xABC = 2748
      fb = frame_cnt[0];
      rb = rise_cnt[0];
      apply_stimulus(0, 16'hABC0, 12'hABC, 32'h32373438, 1'b0);
      wait_done(0, 1, 3000, "inst0_single");
      check_output("inst0_single_frames", frame_cnt[0] - 32'(fb), 32'd1);
      check_output("inst0_single_sclk_periods", rise_cnt[0] - 32'(rb), 32'd16);

      // Four-frame average: (1+2+3+4)/4 = 2
      fb = frame_cnt[1];
      frame_q[1].push_back(16'h0010);
      frame_q[1].push_back(16'h0020);
      frame_q[1].push_back(16'h0030);
      frame_q[1].push_back(16'h0040);
      push_expect(1, 12'h002, 32'h30303032, 1'b0);
      pulse_start(1);
      wait_done(1, 1, 6000, "inst1_avg");
      check_output("inst1_avg_frames", frame_cnt[1] - 32'(fb), 32'd4);
      check_output("inst1_min_gap_cycles", min_gap[1], 32'd8);

      // Three digits: 4095 overflows 999
      apply_stimulus(2, 16'hFFF0, 12'hFFF, 32'h00393939, 1'b1);
      wait_done(2, 1, 3000, "inst2_ovf");

      // Reset after five sclk periods of a frame
      frame_q[0].push_back(16'h1230);
      rb = rise_cnt[0];
      pulse_start(0);
      n = 0;
      while (!((rise_cnt[0] - 32'(rb) >= 32'd5) && (sclk_v[0] == 1'b0)) && (n < 2000)) begin
         @(negedge clk);
         n++;
      end
      check_output("inst0_abort_periods_seen", rise_cnt[0] - 32'(rb), 32'd5);
      #2 rst = 1'b1;
      #1;
      check_output("inst0_abort_ss", 32'(ss_v[0]), 32'd1);
      check_output("inst0_abort_sclk", 32'(sclk_v[0]), 32'd0);
      check_output("inst0_abort_busy", 32'(busy_v[0]), 32'd0);
      check_output("inst0_abort_raw", 32'(raw_v[0]), 32'd0);
      check_output("inst0_abort_ascii", ascii_v[0], 32'h30303030);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      apply_stimulus(0, 16'h0640, 12'h064, 32'h30313030, 1'b0);
      wait_done(0, 2, 3000, "inst0_after_abort");

      // start re-pulsed while busy must not add a frame
      fb = frame_cnt[0];
      apply_stimulus(0, 16'h0050, 12'h005, 32'h30303035, 1'b0);
      repeat (20) @(negedge clk);
      pulse_start(0);
      wait_done(0, 3, 3000, "inst0_repulse");
      repeat (300) @(negedge clk);
      check_output("inst0_repulse_frames", frame_cnt[0] - 32'(fb), 32'd1);
      check_output("inst0_repulse_busy_idle", 32'(busy_v[0]), 32'd0);

      // Continuous mode, dropped during the third measurement
      fb = frame_cnt[0];
      frame_q[0].push_back(16'h0070);
      frame_q[0].push_back(16'h0080);
      frame_q[0].push_back(16'h0090);
      push_expect(0, 12'h007, 32'h30303037, 1'b0);
      push_expect(0, 12'h008, 32'h30303038, 1'b0);
      push_expect(0, 12'h009, 32'h30303039, 1'b0);
      cont_v[0] = 1'b1;
      pulse_start(0);
      wait_done(0, 5, 6000, "inst0_cont_second");
      repeat (3) @(negedge clk);
      check_output("inst0_cont_busy_held", 32'(busy_v[0]), 32'd1);
      cont_v[0] = 1'b0;
      wait_done(0, 6, 3000, "inst0_cont_third");
      repeat (300) @(negedge clk);
      check_output("inst0_cont_frames", frame_cnt[0] - 32'(fb), 32'd3);
      check_output("inst0_cont_busy_idle", 32'(busy_v[0]), 32'd0);
      check_output("inst0_cont_total_dones", done_cnt[0], 32'd6);

      for (int k = 0; k < 3; k++) begin
         check_output($sformatf("inst%0d_sclk_while_ss_high", k), sclk_viol[k], 32'd0);
         check_output($sformatf("inst%0d_done_on_busy_rise", k), done_viol[k], 32'd0);
         check_output($sformatf("inst%0d_unexpected_done", k), extra_done[k], 32'd0);
      end

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule

// File: doc/adc_bcd_readout.md
ADC_BCD_READOUT -- requirements
Module: adc_bcd_readout

Interface
REQ-001 Parameter FRAME_BITS, default 16, SPI frame length in bits.
REQ-002 Parameter RES_BITS, default 12, sample width taken from frame[FRAME_BITS-1 : FRAME_BITS-RES_BITS]; RES_BITS <= FRAME_BITS.
REQ-003 Parameter DIGITS, default 4, decimal digits produced.
REQ-004 Parameter AVG_LOG2, default 2, frames averaged per result = 2^AVG_LOG2; 0 means no averaging.
REQ-005 Parameter CLK_DIV, default 4, sclk half-period in clk cycles, >= 1.
REQ-006 clk  input  1  clock, all logic on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 start  input  1  request one measurement; sampled when idle.
REQ-009 cont  input  1  continuous mode; when high, a new measurement begins automatically after each done.
REQ-010 miso  input  1  ADC serial data.
REQ-011 ss  output  1  ADC chip select, active-low.
REQ-012 sclk  output  1  ADC serial clock, idle low.
REQ-013 busy  output  1  high from acceptance of start until done.
REQ-014 done  output  1  one-cycle pulse when results update.
REQ-015 ovf  output  1  averaged value exceeds 10^DIGITS-1.
REQ-016 raw_avg  output  RES_BITS  averaged binary sample.
REQ-017 ascii  output  DIGITS*8  ASCII decimal digits, least significant digit in bits [7:0].

Function
REQ-018 States IDLE, FRAME, GAP, AVG, BCD, DONE; IDLE->FRAME when start=1 (busy rises next cycle).
REQ-019 start or cont changes while busy=1 shall be ignored until DONE.
REQ-020 FRAME: ss low; after CLK_DIV cycles sclk toggles every CLK_DIV cycles for FRAME_BITS full periods; miso sampled on clk edge producing each sclk rising edge, MSB first.
REQ-021 After the last sclk falling edge ss rises; GAP holds ss high for 2*CLK_DIV cycles.
REQ-022 Each frame's sample is zero-extended and added to an accumulator of RES_BITS+AVG_LOG2 bits; accumulator cleared on leaving IDLE and on leaving DONE.
REQ-023 GAP->FRAME until 2^AVG_LOG2 frames captured, then GAP->AVG.
REQ-024 AVG (1 cycle): raw_avg <= accumulator >> AVG_LOG2 (truncation).
REQ-025 BCD: iterative shift-add-3 conversion of raw_avg, exactly RES_BITS cycles, no sclk activity.
REQ-026 If raw_avg > 10^DIGITS-1: ovf=1 and every ascii byte = 8'h39; else ovf=0 and each byte = 8'h30 + digit.
REQ-027 DONE (1 cycle): ascii, ovf, raw_avg registered outputs update; done=1; busy=0 next cycle if cont=0.
REQ-028 DONE->FRAME if cont=1 (busy stays high), else DONE->IDLE.
REQ-029 ascii, ovf, raw_avg hold their values between done pulses.
REQ-030 start and cont both high in IDLE: measurement starts, then continuous loop.

Reset
REQ-031 On rst: state IDLE, ss=1, sclk=0, busy=0, done=0, ovf=0, raw_avg=0, ascii every byte 8'h30, accumulator and counters 0.
REQ-032 rst asserted mid-frame shall force ss=1 and sclk=0 immediately (asynchronously) and discard partial data.

Verification (defaults unless stated)
REQ-033 AVG_LOG2=0, ADC model returns 16'hABC0, start pulse -> one frame of 16 sclk periods, raw_avg=12'hABC, ascii=32'h32373438 ("2748"), ovf=0, single done pulse.
REQ-034 Frames 16'h0010, 16'h0020, 16'h0030, 16'h0040 -> four ss-low windows separated by >=8 cycles high, raw_avg=2, ascii=32'h30303032.
REQ-035 DIGITS=3, AVG_LOG2=0, frame 16'hFFF0 -> raw_avg=12'hFFF, ovf=1, ascii=24'h393939.
REQ-036 rst raised after 5 sclk periods -> ss=1, sclk=0 same cycle, busy=0, ascii=32'h30303030; later start gives correct fresh result.
REQ-037 start re-pulsed while busy -> no extra frame, one done only; cont=1 -> back-to-back measurements with done pulses, stopping after cont drops (current measurement completes).
REQ-038 Checker: sclk never toggles while ss=1; done never coincides with busy rising from 0.
